// File: rtl/storebuf_be_pkg.sv
// Shared defaults for the byte-enable store buffer and its memory write port.
package storebuf_be_pkg;

  localparam int unsigned STBUF_DEPTH       = 8;
  localparam int unsigned STBUF_DATA_LEN    = 32;
  localparam int unsigned STBUF_ADDR_LEN    = 32;
  localparam int unsigned STBUF_SPECTAG_LEN = 5;

  function automatic int unsigned be_len(int unsigned data_len);
    return data_len / 8;
  endfunction

  localparam int unsigned STBUF_BE_LEN = be_len(STBUF_DATA_LEN);

endpackage

// File: rtl/storebuf_be_if.sv
// Valid/ready memory write port driven by the store buffer head entry.
interface storebuf_be_if import storebuf_be_pkg::*; #(
  parameter int unsigned ADDR_LEN = STBUF_ADDR_LEN,
  parameter int unsigned DATA_LEN = STBUF_DATA_LEN,
  parameter int unsigned BE_LEN   = STBUF_BE_LEN
) ();

  logic                valid;
  logic                ready;
  logic [ADDR_LEN-1:0] addr;
  logic [DATA_LEN-1:0] data;
  logic [BE_LEN-1:0]   be;

  modport master (output valid, addr, data, be, input ready);
  modport slave  (input valid, addr, data, be, output ready);

endinterface

// File: rtl/stbuf_age_prio.sv
// Circular priority pick: youngest (or oldest) set bit of a match vector relative to a base pointer.
module stbuf_age_prio import storebuf_be_pkg::*; #(
  parameter int unsigned DEPTH        = STBUF_DEPTH,
  parameter bit          OLDEST_FIRST = 1'b0,
  localparam int unsigned PTR         = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] match,
  input  logic [PTR-1:0]   base,
  output logic [PTR-1:0]   idx,
  output logic             found
);

  // rot[k] = match[(base + k) mod DEPTH]; k = DEPTH-1 is the slot just below base
  logic [DEPTH-1:0] rot;
  logic [PTR-1:0]   off;

  assign rot = DEPTH'({match, match} >> base);

  always_comb begin
    off   = '0;
    found = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (OLDEST_FIRST) begin
        if (rot[DEPTH-1-k]) begin
          off   = PTR'(DEPTH - 1 - k);
          found = 1'b1;
        end
      end else if (rot[k]) begin
        off   = PTR'(k);
        found = 1'b1;
      end
    end
  end

  assign idx = base + off;

endmodule

// File: rtl/storebuf_be.sv
// In-order store buffer with byte enables, youngest-first byte forwarding and speculative kill.
module storebuf_be import storebuf_be_pkg::*; #(
  parameter int unsigned DEPTH       = STBUF_DEPTH,
  parameter int unsigned DATA_LEN    = STBUF_DATA_LEN,
  parameter int unsigned ADDR_LEN    = STBUF_ADDR_LEN,
  parameter int unsigned SPECTAG_LEN = STBUF_SPECTAG_LEN,
  localparam int unsigned BE_LEN     = be_len(DATA_LEN),
  localparam int unsigned PTR        = $clog2(DEPTH),
  localparam int unsigned OFF        = $clog2(BE_LEN)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   prsuccess,
  input  logic                   prmiss,
  input  logic [SPECTAG_LEN-1:0] prtag,
  input  logic [SPECTAG_LEN-1:0] spectagfix,
  input  logic                   stfin,
  input  logic                   stspecbit,
  input  logic [SPECTAG_LEN-1:0] stspectag,
  input  logic [ADDR_LEN-1:0]    staddr,
  input  logic [DATA_LEN-1:0]    stdata,
  input  logic [BE_LEN-1:0]      stbe,
  input  logic                   stcom,
  storebuf_be_if.master          mem_req,
  input  logic [ADDR_LEN-1:0]    ldaddr,
  input  logic [BE_LEN-1:0]      ld_be,
  output logic [DATA_LEN-1:0]    ld_fwd_data,
  output logic [BE_LEN-1:0]      ld_fwd_mask,
  output logic                   ld_full_hit,
  output logic                   sb_full,
  output logic                   sb_empty,
  output logic [PTR:0]           sb_count
);

  logic [PTR-1:0]         head_q, comptr_q, tail_q;
  logic [PTR:0]           count_q;
  logic [DEPTH-1:0]       valid_q, completed_q, specbit_q;
  logic [SPECTAG_LEN-1:0] spectag_q [DEPTH];
  logic [ADDR_LEN-1:0]    addr_q    [DEPTH];
  logic [DATA_LEN-1:0]    data_q    [DEPTH];
  logic [BE_LEN-1:0]      be_q      [DEPTH];

  assign sb_count = count_q;
  assign sb_full  = (count_q == (PTR+1)'(DEPTH));
  assign sb_empty = (count_q == '0);

  assign mem_req.valid = valid_q[head_q] & completed_q[head_q] & ~prmiss;
  assign mem_req.addr  = addr_q[head_q];
  assign mem_req.data  = data_q[head_q];
  assign mem_req.be    = be_q[head_q];

  logic retire;
  assign retire = mem_req.valid & mem_req.ready;

  // Killed entries form a youngest suffix, so the oldest killed slot marks the survivor count.
  logic [DEPTH-1:0] kill;
  logic [PTR-1:0]   kill_idx;
  logic             kill_found;
  logic [PTR:0]     survivors;

  always_comb begin
    kill = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill[i] = valid_q[i] & specbit_q[i] & |(spectag_q[i] & spectagfix);
    end
  end

  stbuf_age_prio #(
    .DEPTH        (DEPTH),
    .OLDEST_FIRST (1'b1)
  ) u_kill_prio (
    .match (kill),
    .base  (head_q),
    .idx   (kill_idx),
    .found (kill_found)
  );

  assign survivors = kill_found ? {1'b0, kill_idx - head_q} : count_q;

  logic           st_killed, alloc, alloc_spec, com;
  logic [PTR-1:0] base_tail, tail_d, comptr_d, comptr_off, head_d;
  logic [PTR:0]   base_count, count_d;

  always_comb begin
    st_killed  = stspecbit & |(stspectag & spectagfix);
    base_tail  = prmiss ? head_q + survivors[PTR-1:0] : tail_q;
    base_count = prmiss ? survivors : count_q - {{PTR{1'b0}}, retire};
    alloc      = stfin & (prmiss ? (~st_killed & (survivors != (PTR+1)'(DEPTH))) : ~sb_full);
    alloc_spec = stspecbit & ~prmiss & ~(prsuccess & (stspectag == prtag));
    tail_d     = base_tail + PTR'(alloc);
    count_d    = base_count + (PTR+1)'(alloc);
    com        = stcom & valid_q[comptr_q] & ~completed_q[comptr_q] & ~(prmiss & kill[comptr_q]);
    comptr_d   = comptr_q + PTR'(com);
    comptr_off = comptr_d - head_q;
    if (prmiss && ({1'b0, comptr_off} > survivors)) begin
      comptr_d = base_tail;
    end
    head_d     = head_q + PTR'(retire);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= '0;
      comptr_q    <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      completed_q <= '0;
      specbit_q   <= '0;
    end else begin
      head_q   <= head_d;
      comptr_q <= comptr_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (prmiss) begin
          specbit_q[i] <= 1'b0;
          if (kill[i]) begin
            valid_q[i]     <= 1'b0;
            completed_q[i] <= 1'b0;
          end
        end else if (prsuccess && (spectag_q[i] == prtag)) begin
          specbit_q[i] <= 1'b0;
        end
      end
      if (retire) begin
        valid_q[head_q]     <= 1'b0;
        completed_q[head_q] <= 1'b0;
      end
      if (com) begin
        completed_q[comptr_q] <= 1'b1;
      end
      if (alloc) begin
        valid_q[base_tail]     <= 1'b1;
        completed_q[base_tail] <= 1'b0;
        specbit_q[base_tail]   <= alloc_spec;
        spectag_q[base_tail]   <= stspectag;
        addr_q[base_tail]      <= staddr;
        data_q[base_tail]      <= stdata;
        be_q[base_tail]        <= stbe;
      end
    end
  end

  // Only the word part of the load address takes part in matching.
  logic unused_ldaddr;
  assign unused_ldaddr = ^ldaddr;

  for (genvar b = 0; b < BE_LEN; b++) begin : g_lane
    logic [DEPTH-1:0] lane_match;
    logic [PTR-1:0]   lane_idx;
    logic             lane_found;

    always_comb begin
      lane_match = '0;
      for (int i = 0; i < DEPTH; i++) begin
        lane_match[i] = valid_q[i] & be_q[i][b] &
                        (addr_q[i][ADDR_LEN-1:OFF] == ldaddr[ADDR_LEN-1:OFF]);
      end
    end

    stbuf_age_prio #(
      .DEPTH        (DEPTH),
      .OLDEST_FIRST (1'b0)
    ) u_lane_prio (
      .match (lane_match),
      .base  (tail_q),
      .idx   (lane_idx),
      .found (lane_found)
    );

    assign ld_fwd_mask[b]       = lane_found;
    assign ld_fwd_data[8*b +: 8] = lane_found ? data_q[lane_idx][8*b +: 8] : 8'h00;
  end

  assign ld_full_hit = ((ld_fwd_mask & ld_be) == ld_be) && (ld_be != '0);

endmodule

// File: tb/tb_storebuf_be.sv
// Directed self-checking bench for storebuf_be with hand-computed expectations.
module tb_storebuf_be;

  logic        clk = 1'b0;
  logic        reset;
  logic        prsuccess, prmiss;
  logic [4:0]  prtag, spectagfix;
  logic        stfin, stspecbit;
  logic [4:0]  stspectag;
  logic [31:0] staddr, stdata;
  logic [3:0]  stbe;
  logic        stcom;
  logic [31:0] ldaddr;
  logic [3:0]  ld_be;
  logic [31:0] ld_fwd_data;
  logic [3:0]  ld_fwd_mask;
  logic        ld_full_hit, sb_full, sb_empty;
  logic [3:0]  sb_count;

  int n_cmp = 0;
  int n_err = 0;

  storebuf_be_if mem_req ();

  storebuf_be dut (
    .clk         (clk),
    .reset       (reset),
    .prsuccess   (prsuccess),
    .prmiss      (prmiss),
    .prtag       (prtag),
    .spectagfix  (spectagfix),
    .stfin       (stfin),
    .stspecbit   (stspecbit),
    .stspectag   (stspectag),
    .staddr      (staddr),
    .stdata      (stdata),
    .stbe        (stbe),
    .stcom       (stcom),
    .mem_req     (mem_req),
    .ldaddr      (ldaddr),
    .ld_be       (ld_be),
    .ld_fwd_data (ld_fwd_data),
    .ld_fwd_mask (ld_fwd_mask),
    .ld_full_hit (ld_full_hit),
    .sb_full     (sb_full),
    .sb_empty    (sb_empty),
    .sb_count    (sb_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    prsuccess = 0; prmiss = 0; prtag = 0; spectagfix = 0;
    stfin = 0; stspecbit = 0; stspectag = 0; staddr = 0; stdata = 0; stbe = 0;
    stcom = 0; mem_req.ready = 0; ldaddr = 0; ld_be = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      input logic sp, input logic [4:0] tg);
    stfin = 1; staddr = a; stdata = d; stbe = be; stspecbit = sp; stspectag = tg;
    step();
    stfin = 0; stspecbit = 0;
  endtask

  task automatic test_reset();
    do_reset();
    ld_be = 4'hF;
    #2;
    n_cmp++; if (sb_count !== 4'd0) begin n_err++; $display("FAIL rst_count got %0d exp 0", sb_count); end
    n_cmp++; if (sb_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got %b exp 1", sb_empty); end
    n_cmp++; if (sb_full !== 1'b0) begin n_err++; $display("FAIL rst_full got %b exp 0", sb_full); end
    n_cmp++; if (mem_req.valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", mem_req.valid); end
    n_cmp++; if (ld_fwd_mask !== 4'h0) begin n_err++; $display("FAIL rst_mask got %h exp 0", ld_fwd_mask); end
    n_cmp++; if (ld_full_hit !== 1'b0) begin n_err++; $display("FAIL rst_hit got %b exp 0", ld_full_hit); end
    // reset while three entries are held, one of them already committed
    push(32'h800, 32'h1, 4'hF, 0, 0);
    push(32'h804, 32'h2, 4'hF, 0, 0);
    push(32'h808, 32'h3, 4'hF, 0, 0);
    stcom = 1;
    step();
    stcom = 0;
    ldaddr = 32'h800;
    #2;
    n_cmp++; if (sb_count !== 4'd3) begin n_err++; $display("FAIL held_count got %0d exp 3", sb_count); end
    n_cmp++; if (mem_req.valid !== 1'b1) begin n_err++; $display("FAIL held_valid got %b exp 1", mem_req.valid); end
    reset = 1;
    step();
    reset = 0;
    #2;
    n_cmp++; if (sb_count !== 4'd0) begin n_err++; $display("FAIL midrst_count got %0d exp 0", sb_count); end
    n_cmp++; if (sb_empty !== 1'b1) begin n_err++; $display("FAIL midrst_empty got %b exp 1", sb_empty); end
    n_cmp++; if (mem_req.valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %b exp 0", mem_req.valid); end
    n_cmp++; if (ld_fwd_mask !== 4'h0) begin n_err++; $display("FAIL midrst_mask got %h exp 0", ld_fwd_mask); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < 8; i++) push(32'h200 + 32'(4 * i), 32'h1000 + 32'(i), 4'hF, 0, 0);
    #2;
    n_cmp++; if (sb_full !== 1'b1) begin n_err++; $display("FAIL fill_full got %b exp 1", sb_full); end
    n_cmp++; if (sb_count !== 4'd8) begin n_err++; $display("FAIL fill_count got %0d exp 8", sb_count); end
    push(32'hFF0, 32'hBAD, 4'hF, 0, 0);
    #2;
    n_cmp++; if (sb_count !== 4'd8) begin n_err++; $display("FAIL drop9_count got %0d exp 8", sb_count); end
    mem_req.ready = 1;
    for (int k = 0; k <= 8; k++) begin
      stcom = (k < 8);
      #2;
      if (k == 0) begin
        n_cmp++; if (mem_req.valid !== 1'b0) begin n_err++; $display("FAIL drain_lat got %b exp 0", mem_req.valid); end
      end else begin
        n_cmp++;
        if (mem_req.valid !== 1'b1 || mem_req.addr !== 32'h200 + 32'(4 * (k - 1)) ||
            mem_req.data !== 32'h1000 + 32'(k - 1)) begin
          n_err++;
          $display("FAIL drain_%0d got v=%b a=%h d=%h exp v=1 a=%h d=%h", k, mem_req.valid,
                   mem_req.addr, mem_req.data, 32'h200 + 32'(4 * (k - 1)), 32'h1000 + 32'(k - 1));
        end
      end
      step();
    end
    stcom = 0;
    mem_req.ready = 0;
    #2;
    n_cmp++; if (sb_empty !== 1'b1) begin n_err++; $display("FAIL drain_empty got %b exp 1", sb_empty); end
    n_cmp++; if (mem_req.valid !== 1'b0) begin n_err++; $display("FAIL drain_idle got %b exp 0", mem_req.valid); end
  endtask

  task automatic test_forward();
    do_reset();
    push(32'h100, 32'hAABBCCDD, 4'hF, 0, 0);
    push(32'h100, 32'h00001122, 4'h3, 0, 0);
    ldaddr = 32'h100; ld_be = 4'hF;
    #2;
    n_cmp++; if (ld_fwd_data !== 32'hAABB1122) begin n_err++; $display("FAIL fwd_data got %h exp aabb1122", ld_fwd_data); end
    n_cmp++; if (ld_fwd_mask !== 4'hF) begin n_err++; $display("FAIL fwd_mask got %h exp f", ld_fwd_mask); end
    n_cmp++; if (ld_full_hit !== 1'b1) begin n_err++; $display("FAIL fwd_hit got %b exp 1", ld_full_hit); end
    ldaddr = 32'h102;
    #1;
    n_cmp++; if (ld_fwd_data !== 32'hAABB1122) begin n_err++; $display("FAIL fwd_off got %h exp aabb1122", ld_fwd_data); end
    ldaddr = 32'h104;
    #1;
    n_cmp++; if (ld_fwd_mask !== 4'h0) begin n_err++; $display("FAIL fwd_miss_mask got %h exp 0", ld_fwd_mask); end
    n_cmp++; if (ld_fwd_data !== 32'h0) begin n_err++; $display("FAIL fwd_miss_data got %h exp 0", ld_fwd_data); end
    n_cmp++; if (ld_full_hit !== 1'b0) begin n_err++; $display("FAIL fwd_miss_hit got %b exp 0", ld_full_hit); end
  endtask

  task automatic test_kill();
    do_reset();
    push(32'h300, 32'hA0, 4'hF, 0, 5'b00000);
    push(32'h304, 32'hA1, 4'hF, 0, 5'b00000);
    push(32'h308, 32'hA2, 4'hF, 1, 5'b00010);
    push(32'h30C, 32'hA3, 4'hF, 1, 5'b00010);
    push(32'h310, 32'hA4, 4'hF, 1, 5'b00010);
    prmiss = 1; spectagfix = 5'b00010; prtag = 5'b00010;
    stfin = 1; stspecbit = 1; stspectag = 5'b00100; staddr = 32'h340; stdata = 32'h55; stbe = 4'hF;
    step();
    idle();
    ldaddr = 32'h340; ld_be = 4'hF;
    #2;
    n_cmp++; if (sb_count !== 4'd3) begin n_err++; $display("FAIL kill_count got %0d exp 3", sb_count); end
    n_cmp++; if (dut.addr_q[2] !== 32'h340) begin n_err++; $display("FAIL kill_slot got %h exp 340", dut.addr_q[2]); end
    n_cmp++; if (dut.specbit_q !== 8'h00) begin n_err++; $display("FAIL kill_spec got %h exp 00", dut.specbit_q); end
    n_cmp++; if (ld_fwd_data !== 32'h55) begin n_err++; $display("FAIL kill_new_fwd got %h exp 55", ld_fwd_data); end
    ldaddr = 32'h308;
    #1;
    n_cmp++; if (ld_fwd_mask !== 4'h0) begin n_err++; $display("FAIL kill_gone got %h exp 0", ld_fwd_mask); end
    // new entry must now be non-speculative and survive a miss on its own tag
    prmiss = 1; spectagfix = 5'b00100;
    step();
    idle();
    #2;
    n_cmp++; if (sb_count !== 4'd3) begin n_err++; $display("FAIL kill_again got %0d exp 3", sb_count); end
    mem_req.ready = 1;
    for (int k = 0; k <= 3; k++) begin
      stcom = (k < 3);
      #2;
      if (k > 0) begin
        n_cmp++;
        if (mem_req.valid !== 1'b1 || mem_req.addr !== ((k == 3) ? 32'h340 : 32'h300 + 32'(4 * (k - 1)))) begin
          n_err++;
          $display("FAIL kill_drain_%0d got v=%b a=%h", k, mem_req.valid, mem_req.addr);
        end
      end
      step();
    end
    idle();
    // same-cycle store carrying the killed tag is dropped
    do_reset();
    push(32'h300, 32'hA0, 4'hF, 0, 5'b00000);
    push(32'h304, 32'hA1, 4'hF, 0, 5'b00000);
    push(32'h308, 32'hA2, 4'hF, 1, 5'b00010);
    push(32'h30C, 32'hA3, 4'hF, 1, 5'b00010);
    push(32'h310, 32'hA4, 4'hF, 1, 5'b00010);
    prmiss = 1; spectagfix = 5'b00010;
    stfin = 1; stspecbit = 1; stspectag = 5'b00010; staddr = 32'h340; stdata = 32'h55; stbe = 4'hF;
    step();
    idle();
    ldaddr = 32'h340; ld_be = 4'hF;
    #2;
    n_cmp++; if (sb_count !== 4'd2) begin n_err++; $display("FAIL kdrop_count got %0d exp 2", sb_count); end
    n_cmp++; if (ld_fwd_mask !== 4'h0) begin n_err++; $display("FAIL kdrop_mask got %h exp 0", ld_fwd_mask); end
  endtask

  task automatic test_prsuccess();
    do_reset();
    push(32'h900, 32'h1, 4'hF, 1, 5'b00001);
    prsuccess = 1; prtag = 5'b00001;
    push(32'h904, 32'h2, 4'hF, 1, 5'b00001);
    prsuccess = 0;
    push(32'h908, 32'h3, 4'hF, 1, 5'b00001);
    prmiss = 1; spectagfix = 5'b00001;
    step();
    idle();
    ldaddr = 32'h904; ld_be = 4'hF;
    #2;
    n_cmp++; if (sb_count !== 4'd2) begin n_err++; $display("FAIL prs_count got %0d exp 2", sb_count); end
    n_cmp++; if (ld_fwd_mask !== 4'hF) begin n_err++; $display("FAIL prs_keep got %h exp f", ld_fwd_mask); end
    ldaddr = 32'h908;
    #1;
    n_cmp++; if (ld_fwd_mask !== 4'h0) begin n_err++; $display("FAIL prs_kill got %h exp 0", ld_fwd_mask); end
  endtask

  task automatic test_backpressure();
    do_reset();
    push(32'h400, 32'hDEADBEEF, 4'h5, 0, 0);
    stcom = 1;
    #2;
    n_cmp++; if (mem_req.valid !== 1'b0) begin n_err++; $display("FAIL bp_lat got %b exp 0", mem_req.valid); end
    step();
    stcom = 0;
    for (int k = 0; k < 5; k++) begin
      #2;
      n_cmp++;
      if (mem_req.valid !== 1'b1 || mem_req.addr !== 32'h400 || mem_req.data !== 32'hDEADBEEF ||
          mem_req.be !== 4'h5) begin
        n_err++;
        $display("FAIL bp_hold_%0d got v=%b a=%h d=%h be=%h exp v=1 a=400 d=deadbeef be=5", k,
                 mem_req.valid, mem_req.addr, mem_req.data, mem_req.be);
      end
      step();
    end
    prmiss = 1;
    #2;
    n_cmp++; if (mem_req.valid !== 1'b0) begin n_err++; $display("FAIL bp_miss got %b exp 0", mem_req.valid); end
    step();
    prmiss = 0;
    #2;
    n_cmp++; if (mem_req.valid !== 1'b1) begin n_err++; $display("FAIL bp_back got %b exp 1", mem_req.valid); end
    n_cmp++; if (sb_count !== 4'd1) begin n_err++; $display("FAIL bp_count got %0d exp 1", sb_count); end
    mem_req.ready = 1;
    step();
    mem_req.ready = 0;
    #2;
    n_cmp++; if (sb_empty !== 1'b1) begin n_err++; $display("FAIL bp_done got %b exp 1", sb_empty); end
  endtask

  task automatic test_wrap();
    do_reset();
    mem_req.ready = 1;
    for (int i = 0; i < 14; i++) begin
      push(32'hA00 + 32'(4 * i), 32'(i), 4'hF, 0, 0);
      stcom = 1;
      step();
      stcom = 0;
    end
    step();
    #2;
    n_cmp++; if (sb_empty !== 1'b1) begin n_err++; $display("FAIL wrap_pre got %b exp 1", sb_empty); end
    push(32'h600, 32'h11111111, 4'hF, 0, 0);
    push(32'h600, 32'h22222222, 4'h3, 0, 0);
    push(32'h600, 32'h33333333, 4'h6, 0, 0);
    push(32'h700, 32'h44444444, 4'hF, 0, 0);
    ldaddr = 32'h600; ld_be = 4'hF;
    #2;
    n_cmp++; if (sb_count !== 4'd4) begin n_err++; $display("FAIL wrap_count got %0d exp 4", sb_count); end
    n_cmp++; if (ld_fwd_data !== 32'h11333322) begin n_err++; $display("FAIL wrap_data got %h exp 11333322", ld_fwd_data); end
    n_cmp++; if (ld_fwd_mask !== 4'hF) begin n_err++; $display("FAIL wrap_mask got %h exp f", ld_fwd_mask); end
    ldaddr = 32'h603; ld_be = 4'h8;
    #1;
    n_cmp++; if (ld_full_hit !== 1'b1) begin n_err++; $display("FAIL wrap_hit got %b exp 1", ld_full_hit); end
    ldaddr = 32'h700; ld_be = 4'hF;
    #1;
    n_cmp++; if (ld_fwd_data !== 32'h44444444) begin n_err++; $display("FAIL wrap_other got %h exp 44444444", ld_fwd_data); end
  endtask

  initial begin
    idle();
    reset = 1;
    test_reset();
    test_fill_drain();
    test_forward();
    test_kill();
    test_prsuccess();
    test_backpressure();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
